// File: rtl/cpu_types_pkg.sv
// Shared core types: pipeline sequencer states and the Mem control-field encoding.
package cpu_types_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MEMWAIT = 2'd1,
    HALTING = 2'd2,
    HALTED  = 2'd3
  } seq_state_t;

  localparam logic [1:0] MEM_NONE  = 2'b00;
  localparam logic [1:0] MEM_LOAD  = 2'b01;
  localparam logic [1:0] MEM_STORE = 2'b10;

endpackage

// File: rtl/hazard_detect.sv
// Load-use compare: a load in ID/EX whose destination feeds the instruction in IF/ID.
module hazard_detect
  import cpu_types_pkg::*;
(
  input  logic [1:0] idex_mem,
  input  logic [4:0] idex_rd,
  input  logic [4:0] ifid_rs,
  input  logic [4:0] ifid_rt,
  output logic       lu
);

  // r0 is hardwired to zero, so a load targeting it never creates a dependency
  assign lu = (idex_mem == MEM_LOAD) && (idex_rd != 5'd0) &&
              ((idex_rd == ifid_rs) || (idex_rd == ifid_rt));

endmodule

// File: rtl/pipeline_sequencer.sv
// Central pipeline controller: latch enables/flushes, PC write enable, halt drain
// and a saturating stall-cycle counter for the 5-stage core.
//
// state   | meaning
// RUN     | normal issue; hazards resolved combinationally each cycle
// MEMWAIT | data access outstanding; pipeline frozen until dhit
// HALTING | halt reached MEM/WB; pipeline frozen while the drain counter runs
// HALTED  | core stopped; only reset leaves this state
module pipeline_sequencer
  import cpu_types_pkg::*;
#(
  parameter int DRAIN_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic [1:0]       exmem_mem,
  input  logic [1:0]       idex_mem,
  input  logic [4:0]       idex_rd,
  input  logic [4:0]       ifid_rs,
  input  logic [4:0]       ifid_rt,
  input  logic             br_taken,
  input  logic             memwb_halt,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt
);

  seq_state_t state;
  logic [3:0] drain_cnt;
  logic       dreq;
  logic       lu;
  logic       run_eval;

  hazard_detect u_hazard_detect (
    .idex_mem (idex_mem),
    .idex_rd  (idex_rd),
    .ifid_rs  (ifid_rs),
    .ifid_rt  (ifid_rt),
    .lu       (lu)
  );

  assign dreq = (exmem_mem == MEM_LOAD) || (exmem_mem == MEM_STORE);

  // MEMWAIT with dhit re-runs the RUN priorities; dreq is then satisfied by dhit itself
  assign run_eval = (state == RUN) || ((state == MEMWAIT) && dhit);

  always_comb begin
    pc_en       = 1'b0;
    ifid_en     = 1'b0;
    idex_en     = 1'b0;
    exmem_en    = 1'b0;
    memwb_en    = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    if (run_eval && !memwb_halt && !(dreq && !dhit)) begin
      pc_en    = 1'b1;
      ifid_en  = 1'b1;
      idex_en  = 1'b1;
      exmem_en = 1'b1;
      memwb_en = 1'b1;
      if (br_taken) begin
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
      end else if (lu) begin
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        idex_flush = 1'b1;
      end else if (!ihit) begin
        pc_en      = 1'b0;
        ifid_flush = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state     <= RUN;
      halted    <= 1'b0;
      stall_cnt <= '0;
      drain_cnt <= '0;
    end else begin
      if ((state == RUN || state == MEMWAIT) && !pc_en && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CNT_W'(1);
      case (state)
        RUN: begin
          if (memwb_halt) begin
            state     <= HALTING;
            drain_cnt <= 4'd1;
          end else if (dreq && !dhit) begin
            state <= MEMWAIT;
          end
        end
        MEMWAIT: begin
          if (dhit) begin
            if (memwb_halt) begin
              state     <= HALTING;
              drain_cnt <= 4'd1;
            end else begin
              state <= RUN;
            end
          end
        end
        HALTING: begin
          if (drain_cnt == 4'(DRAIN_CYCLES)) begin
            state  <= HALTED;
            halted <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt + 4'd1;
          end
        end
        HALTED:  halted <= 1'b1;
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Directed bench for pipeline_sequencer: RUN-rule vector table plus MEMWAIT,
// halt/reset and counter-saturation sequences.
module tb_pipeline_sequencer;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        ihit, dhit, br_taken, memwb_halt;
  logic [1:0]  exmem_mem, idex_mem;
  logic [4:0]  idex_rd, ifid_rs, ifid_rt;

  logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic        ifid_flush, idex_flush, exmem_flush, halted;
  logic [31:0] stall_cnt;

  logic        s_pc_en, s_ifid_en, s_idex_en, s_exmem_en, s_memwb_en;
  logic        s_ifid_flush, s_idex_flush, s_exmem_flush, s_halted;
  logic [3:0]  s_stall_cnt;

  int tests = 0;
  int fails = 0;
  int exp_stall;

  always #5 CLK = ~CLK;

  pipeline_sequencer #(.DRAIN_CYCLES(2), .CNT_W(32)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
    .exmem_mem(exmem_mem), .idex_mem(idex_mem), .idex_rd(idex_rd),
    .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .br_taken(br_taken),
    .memwb_halt(memwb_halt),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en),
    .exmem_en(exmem_en), .memwb_en(memwb_en),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush),
    .halted(halted), .stall_cnt(stall_cnt)
  );

  pipeline_sequencer #(.DRAIN_CYCLES(2), .CNT_W(4)) dut_sat (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
    .exmem_mem(exmem_mem), .idex_mem(idex_mem), .idex_rd(idex_rd),
    .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .br_taken(br_taken),
    .memwb_halt(memwb_halt),
    .pc_en(s_pc_en), .ifid_en(s_ifid_en), .idex_en(s_idex_en),
    .exmem_en(s_exmem_en), .memwb_en(s_memwb_en),
    .ifid_flush(s_ifid_flush), .idex_flush(s_idex_flush), .exmem_flush(s_exmem_flush),
    .halted(s_halted), .stall_cnt(s_stall_cnt)
  );

  // expected control word: {pc, ifid_en, idex_en, exmem_en, memwb_en, ifid_fl, idex_fl, exmem_fl}
  typedef struct {
    string      name;
    logic       ihit, dhit, br;
    logic [1:0] exmem_mem, idex_mem;
    logic [4:0] rd, rs, rt;
    logic [7:0] exp;
  } vec_t;

  localparam logic [7:0] ALL_ADV = 8'b1111_1000;
  localparam logic [7:0] FROZEN  = 8'b0000_0000;
  localparam logic [7:0] LU_STL  = 8'b0011_1010;
  localparam logic [7:0] IMISS   = 8'b0111_1100;
  localparam logic [7:0] BRANCH  = 8'b1111_1110;

  vec_t vecs[$];

  function automatic logic [7:0] ctl_word();
    return {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, exmem_flush};
  endfunction

  task automatic check_ctl(input string name, input logic [7:0] exp);
    logic [7:0] act;
    act = ctl_word();
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: ctl got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    ihit = 1'b1; dhit = 1'b0; br_taken = 1'b0; memwb_halt = 1'b0;
    exmem_mem = 2'b00; idex_mem = 2'b00; idex_rd = 5'd0; ifid_rs = 5'd0; ifid_rt = 5'd0;
  endtask

  // inputs change at negedge; combinational outputs are sampled 2 ns later
  task automatic settle();
    #2;
  endtask

  task automatic tick();
    @(negedge CLK);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    nRST = 1'b0;
    idle_inputs();
    @(negedge CLK);
    nRST = 1'b1;
    exp_stall = 0;
  endtask

  initial begin
    nRST = 1'b0;
    idle_inputs();
    vecs.push_back('{"idle",        1, 0, 0, 2'b00, 2'b00, 5'd0, 5'd0, 5'd0, ALL_ADV});
    vecs.push_back('{"imiss",       0, 0, 0, 2'b00, 2'b00, 5'd0, 5'd0, 5'd0, IMISS});
    vecs.push_back('{"lu_rt",       1, 0, 0, 2'b00, 2'b01, 5'd5, 5'd0, 5'd5, LU_STL});
    vecs.push_back('{"lu_rd0",      1, 0, 0, 2'b00, 2'b01, 5'd0, 5'd0, 5'd0, ALL_ADV});
    vecs.push_back('{"lu_rs",       1, 0, 0, 2'b00, 2'b01, 5'd7, 5'd7, 5'd3, LU_STL});
    vecs.push_back('{"store_dep",   1, 0, 0, 2'b00, 2'b10, 5'd5, 5'd0, 5'd5, ALL_ADV});
    vecs.push_back('{"load_nodep",  1, 0, 0, 2'b00, 2'b01, 5'd5, 5'd6, 5'd7, ALL_ADV});
    vecs.push_back('{"lu_imiss",    0, 0, 0, 2'b00, 2'b01, 5'd9, 5'd9, 5'd0, LU_STL});
    vecs.push_back('{"br_lu_imiss", 0, 0, 1, 2'b00, 2'b01, 5'd5, 5'd0, 5'd5, BRANCH});
    vecs.push_back('{"br_only",     1, 0, 1, 2'b00, 2'b00, 5'd0, 5'd0, 5'd0, BRANCH});
    vecs.push_back('{"store_dhit",  1, 1, 0, 2'b10, 2'b00, 5'd0, 5'd0, 5'd0, ALL_ADV});
    vecs.push_back('{"mem11_nodreq",1, 0, 0, 2'b11, 2'b00, 5'd0, 5'd0, 5'd0, ALL_ADV});

    do_reset();
    for (int i = 0; i < 3; i++) begin
      settle();
      check_ctl("reset_idle", ALL_ADV);
      tick();
    end
    check_val("reset_halted", 32'(halted), 32'd0);
    check_val("reset_stall", stall_cnt, 32'd0);

    foreach (vecs[i]) begin
      ihit = vecs[i].ihit; dhit = vecs[i].dhit; br_taken = vecs[i].br;
      exmem_mem = vecs[i].exmem_mem; idex_mem = vecs[i].idex_mem;
      idex_rd = vecs[i].rd; ifid_rs = vecs[i].rs; ifid_rt = vecs[i].rt;
      settle();
      check_ctl(vecs[i].name, vecs[i].exp);
      if (vecs[i].exp[7] == 1'b0) exp_stall++;
      tick();
      check_val({vecs[i].name, "_stall"}, stall_cnt, 32'(exp_stall));
    end

    // data miss: one RUN cycle plus three MEMWAIT cycles frozen, released on dhit
    do_reset();
    exmem_mem = 2'b01;
    for (int i = 0; i < 4; i++) begin
      br_taken = (i == 2);
      settle();
      check_ctl("memwait_frozen", FROZEN);
      tick();
    end
    br_taken = 1'b0;
    dhit = 1'b1;
    settle();
    check_ctl("memwait_release", ALL_ADV);
    tick();
    check_val("memwait_stall", stall_cnt, 32'd4);
    idle_inputs();
    settle();
    check_ctl("memwait_back_run", ALL_ADV);
    tick();

    // branch re-presented on the release cycle is honoured
    exmem_mem = 2'b10;
    tick();
    dhit = 1'b1; br_taken = 1'b1;
    settle();
    check_ctl("memwait_release_br", BRANCH);
    tick();
    check_val("memwait_br_stall", stall_cnt, 32'd5);
    idle_inputs();

    // halt drain with DRAIN_CYCLES=2
    do_reset();
    memwb_halt = 1'b1;
    settle();
    check_ctl("halt_enter", FROZEN);
    tick();
    memwb_halt = 1'b0;
    settle();
    check_ctl("halting_frozen", FROZEN);
    check_val("halt_edge1", 32'(halted), 32'd0);
    tick();
    check_val("halt_edge2", 32'(halted), 32'd0);
    tick();
    check_val("halt_edge3", 32'(halted), 32'd1);
    ihit = 1'b0; br_taken = 1'b1; exmem_mem = 2'b01;
    for (int i = 0; i < 3; i++) begin
      settle();
      check_ctl("halted_frozen", FROZEN);
      tick();
    end
    check_val("halted_sticky", 32'(halted), 32'd1);
    check_val("halted_stall", stall_cnt, 32'd1);
    nRST = 1'b0;
    idle_inputs();
    tick();
    nRST = 1'b1;
    check_val("halt_reset_halted", 32'(halted), 32'd0);
    check_val("halt_reset_stall", stall_cnt, 32'd0);
    settle();
    check_ctl("halt_reset_run", ALL_ADV);
    tick();

    // saturation on the 4-bit instance
    do_reset();
    ihit = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    check_val("sat_cnt4", 32'(s_stall_cnt), 32'hF);
    check_val("sat_cnt32", stall_cnt, 32'd20);
    tick();
    check_val("sat_cnt4_hold", 32'(s_stall_cnt), 32'hF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pipeline_sequencer.md
Name: pipeline_sequencer

Overview:
- Central pipeline controller for the 5-stage core.
- Drives the enable and flush inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB latch interfaces, plus the PC write enable.
- Resolves data-memory waits, load-use hazards, taken branches/jumps, instruction-fetch misses and the halt drain.
- Holds a small state machine and a stall counter; one instance per core.

Parameters:
- DRAIN_CYCLES, 2, cycles the frozen pipeline is held after halt reaches MEM/WB before halted asserts (range 1..15).
- CNT_W, 32, width of the stall-cycle counter.

Ports:
- CLK  in  1  core clock
- nRST  in  1  synchronous active-low reset, sampled on rising CLK
- ihit  in  1  instruction fetch complete this cycle
- dhit  in  1  data access complete this cycle
- exmem_mem  in  2  Mem field at EX/MEM output: 2'b01 load, 2'b10 store, else none
- idex_mem  in  2  Mem field at ID/EX output
- idex_rd  in  5  destination register of the instruction in ID/EX
- ifid_rs  in  5  rs of the instruction in IF/ID
- ifid_rt  in  5  rt of the instruction in IF/ID
- br_taken  in  1  branch taken or jump resolved in EX this cycle
- memwb_halt  in  1  halt_o of MEM/WB
- pc_en  out  1  PC write enable
- ifid_en, idex_en, exmem_en, memwb_en  out  1 each  latch enables
- ifid_flush, idex_flush, exmem_flush  out  1 each  load a bubble: all control fields zero
- halted  out  1  core halted, sticky
- stall_cnt  out  CNT_W  count of cycles with pc_en=0 while in RUN or MEMWAIT

Behaviour:
- Clocking and reset:
  - One clock domain.
  - Reset is synchronous and active-low on nRST.
  - On reset: state=RUN, halted=0, stall_cnt=0, drain counter=0.
- Output timing:
  - Enables and flushes are combinational from state and current inputs, valid the same cycle.
  - halted and stall_cnt are registered.
- States: RUN, MEMWAIT, HALTING, HALTED.
- Definitions:
  - dreq = (exmem_mem==2'b01) | (exmem_mem==2'b10).
  - lu = (idex_mem==2'b01) & (idex_rd!=0) & (idex_rd==ifid_rs | idex_rd==ifid_rt).
- RUN, default: all enables 1, all flushes 0.
- RUN, priority 1 (highest): memwb_halt=1.
  - All enables and flushes 0; go to HALTING; drain counter loads 1.
- RUN, priority 2: dreq & !dhit.
  - All enables 0; go to MEMWAIT.
  - The access completes in MEMWAIT.
- RUN, priority 3: br_taken.
  - pc_en=1 (loads target); ifid_flush=1 and idex_flush=1; other latches advance.
  - br_taken overrides lu and !ihit in the same cycle.
- RUN, priority 4: lu.
  - pc_en=0 and ifid_en=0; idex_flush=1; exmem and memwb advance.
- RUN, priority 5: !ihit.
  - pc_en=0; ifid_flush=1 (bubble into ID); the rest advance.
  - lu and !ihit together: lu behaviour applies.
- MEMWAIT, dhit=0:
  - All enables 0.
  - br_taken is ignored: EX is frozen, so it is re-presented.
- MEMWAIT, dhit=1:
  - Re-evaluate the RUN rules with dreq treated as satisfied.
  - Go to RUN the same cycle.
- HALTING:
  - All enables 0; drain counter increments each cycle.
  - When counter==DRAIN_CYCLES, go to HALTED.
- HALTED:
  - All enables 0; halted=1.
  - All inputs are ignored until reset.
- stall_cnt:
  - Increments by 1 each cycle pc_en=0 in RUN or MEMWAIT.
  - Saturates at all-ones; no wrap.
- Reset mid-operation: reset asserted in any state returns to RUN next edge with the values listed above; halted clears.
- memwb_halt while in MEMWAIT: not acted on until the return to RUN. MEM/WB is frozen, so halt persists.

Decomposition:
- Add to cpu_types_pkg:
  - seq_state_t enum (RUN, MEMWAIT, HALTING, HALTED).
  - Mem-field constants MEM_NONE=2'b00, MEM_LOAD=2'b01, MEM_STORE=2'b10.
- Optional sub-module hazard_detect: combinational lu compare. Everything else stays in pipeline_sequencer.

Test Plan:
- Reset, then ihit=1, dhit=0, all other inputs 0 for 3 cycles -> all enables 1, flushes 0, halted=0, stall_cnt=0.
- exmem_mem=01, dhit=0 for 3 cycles, then dhit=1 -> 3 cycles all enables 0 in MEMWAIT, enables 1 on the dhit cycle, stall_cnt=4.
- idex_mem=01, idex_rd=5, ifid_rt=5, one cycle -> pc_en=0, ifid_en=0, idex_flush=1, exmem_en=1; repeat with idex_rd=0 -> no stall.
- br_taken=1 together with the load-use condition and ihit=0 -> pc_en=1, ifid_flush=1, idex_flush=1, stall_cnt unchanged.
- memwb_halt=1 with DRAIN_CYCLES=2 -> all enables 0 from that cycle, halted=1 two edges later, stays 1 with memwb_halt=0; nRST=0 for one edge -> halted=0, state RUN.
- Force stall_cnt near saturation (CNT_W=4 build, 20 stall cycles) -> stall_cnt holds at 4'hF.
